// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router control plane.
package router_pkg;
    localparam int NUM_PORTS         = 3;
    localparam int SOFT_RESET_CYCLES = 30;
    localparam int CNT_W             = 5;

    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        DROP_PKT,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_e;
endpackage

// File: rtl/router_soft_rst_timer.sv
// Per-port watchdog: pulses soft_reset when a non-empty FIFO sits unread too long.
module router_soft_rst_timer
    import router_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic vld_i,
    input  logic read_i,
    input  logic empty_i,
    output logic soft_reset_o
);
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             fire;

    // A read on the threshold cycle wins: no pulse, count restarts.
    assign fire = (cnt_q == CNT_W'(SOFT_RESET_CYCLES - 1)) && vld_i && !read_i;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= fire;
            if (read_i || empty_i || pulse_q || fire)
                cnt_q <= '0;
            else if (vld_i)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign soft_reset_o = pulse_q;
endmodule

// File: rtl/router_ctrl.sv
// Router control FSM: header decode, register-block strobes, FIFO write enables
// and per-port soft-reset timers.
module router_ctrl
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [1:0]           data_in,
    input  logic [NUM_PORTS-1:0] fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] read_enb,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] write_enb,
    output logic [NUM_PORTS-1:0] vld_out,
    output logic [NUM_PORTS-1:0] soft_reset
);
    state_e               state_q;
    logic [1:0]           addr_q;
    logic [NUM_PORTS-1:0] write_enb_q;
    logic [NUM_PORTS-1:0] write_enb_d;
    logic                 wr;
    logic                 soft_hit;

    assign vld_out = ~fifo_empty;

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_tmr
            router_soft_rst_timer u_tmr (
                .clock        (clock),
                .resetn       (resetn),
                .vld_i        (vld_out[p]),
                .read_i       (read_enb[p]),
                .empty_i      (fifo_empty[p]),
                .soft_reset_o (soft_reset[p])
            );
        end
    endgenerate

    assign detect_add  = (state_q == DECODE_ADDRESS);
    assign lfd_state   = (state_q == LOAD_FIRST_DATA);
    assign ld_state    = (state_q == LOAD_DATA);
    assign laf_state   = (state_q == LOAD_AFTER_FULL);
    assign full_state  = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg = (state_q == CHECK_PARITY_ERROR);
    assign busy        = !(detect_add || ld_state || state_q == DROP_PKT);

    // Strobe lags the state by one cycle to line up with the register block's dout.
    assign wr          = lfd_state || (ld_state && !fifo_full[addr_q]) || laf_state;
    assign write_enb_d = wr ? (NUM_PORTS'(1) << addr_q) : '0;
    assign soft_hit    = soft_reset[addr_q] && !detect_add && state_q != DROP_PKT;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= DECODE_ADDRESS;
            addr_q      <= 2'b00;
            write_enb_q <= '0;
        end else begin
            write_enb_q <= write_enb_d;
            if (detect_add && pkt_valid && data_in != ADDR_INVALID)
                addr_q <= data_in;
            if (soft_hit) begin
                state_q <= DECODE_ADDRESS;
            end else begin
                case (state_q)
                    DECODE_ADDRESS:
                        if (pkt_valid) begin
                            if (data_in == ADDR_INVALID)  state_q <= DROP_PKT;
                            else if (fifo_empty[data_in]) state_q <= LOAD_FIRST_DATA;
                            else                          state_q <= WAIT_TILL_EMPTY;
                        end
                    DROP_PKT:
                        if (!pkt_valid) state_q <= DECODE_ADDRESS;
                    WAIT_TILL_EMPTY:
                        if (fifo_empty[addr_q]) state_q <= LOAD_FIRST_DATA;
                    LOAD_FIRST_DATA:
                        state_q <= LOAD_DATA;
                    LOAD_DATA:
                        if (fifo_full[addr_q]) state_q <= FIFO_FULL_STATE;
                        else if (!pkt_valid)   state_q <= LOAD_PARITY;
                    FIFO_FULL_STATE:
                        if (!fifo_full[addr_q]) state_q <= LOAD_AFTER_FULL;
                    LOAD_AFTER_FULL:
                        if (parity_done)        state_q <= DECODE_ADDRESS;
                        else if (low_pkt_valid) state_q <= LOAD_PARITY;
                        else                    state_q <= LOAD_DATA;
                    LOAD_PARITY:
                        state_q <= CHECK_PARITY_ERROR;
                    CHECK_PARITY_ERROR:
                        if (fifo_full[addr_q]) state_q <= FIFO_FULL_STATE;
                        else                   state_q <= DECODE_ADDRESS;
                    default:
                        state_q <= DECODE_ADDRESS;
                endcase
            end
        end
    end

    assign write_enb = write_enb_q;
endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet flow, wait/full/drop paths, soft-reset timer, reset.
module tb_router_ctrl;
    logic       clock = 1'b0;
    logic       resetn, pkt_valid, parity_done, low_pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_full, fifo_empty, read_enb;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic [6:0] st;

    int nvec = 0;
    int nerr = 0;
    int wcnt [3];

    // {detect_add, lfd, ld, laf, full, rst_int_reg, busy}
    localparam logic [6:0] S_DEC  = 7'b1000000;
    localparam logic [6:0] S_LFD  = 7'b0100001;
    localparam logic [6:0] S_LD   = 7'b0010000;
    localparam logic [6:0] S_LAF  = 7'b0001001;
    localparam logic [6:0] S_FFS  = 7'b0000101;
    localparam logic [6:0] S_CPE  = 7'b0000011;
    localparam logic [6:0] S_BUSY = 7'b0000001;
    localparam logic [6:0] S_DROP = 7'b0000000;

    always #5 clock = ~clock;

    router_ctrl dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .read_enb(read_enb),
        .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .busy(busy), .write_enb(write_enb), .vld_out(vld_out), .soft_reset(soft_reset)
    );

    assign st = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy};

    task automatic step();
        @(posedge clock);
        #1;
        for (int p = 0; p < 3; p++) wcnt[p] += int'(write_enb[p]);
    endtask

    task automatic clr_wcnt();
        for (int p = 0; p < 3; p++) wcnt[p] = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 3'b000;
        fifo_empty = 3'b111; read_enb = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        step(); step();
        nvec++; if (st !== S_DEC) begin nerr++; $display("FAIL reset_state got %b want %b", st, S_DEC); end
        nvec++; if (write_enb !== 3'b000) begin nerr++; $display("FAIL reset_wen got %b want 000", write_enb); end
        nvec++; if (soft_reset !== 3'b000) begin nerr++; $display("FAIL reset_srst got %b want 000", soft_reset); end
        resetn = 1'b1;
        fifo_empty = 3'b010;
        #1;
        nvec++; if (vld_out !== 3'b101) begin nerr++; $display("FAIL vld_out got %b want 101", vld_out); end
        fifo_empty = 3'b111;
        step();
    endtask

    task automatic test_packet();
        logic [6:0] exp_st [9];
        logic       pv     [9];
        exp_st = '{S_LFD, S_LD, S_LD, S_LD, S_LD, S_LD, S_BUSY, S_CPE, S_DEC};
        pv     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        clr_wcnt();
        data_in = 2'b01;
        for (int i = 0; i < 9; i++) begin
            pkt_valid = pv[i];
            step();
            nvec++;
            if (st !== exp_st[i]) begin nerr++; $display("FAIL pkt_state[%0d] got %b want %b", i, st, exp_st[i]); end
        end
        nvec++; if (wcnt[1] != 6) begin nerr++; $display("FAIL pkt_wen1_count got %0d want 6", wcnt[1]); end
        nvec++; if (wcnt[0] != 0 || wcnt[2] != 0) begin
            nerr++; $display("FAIL pkt_wen_other got %0d/%0d want 0/0", wcnt[0], wcnt[2]); end
    endtask

    task automatic test_wait_empty();
        clr_wcnt();
        fifo_empty = 3'b011; fifo_full = 3'b100; pkt_valid = 1'b1; data_in = 2'b10;
        step();
        nvec++; if (st !== S_BUSY) begin nerr++; $display("FAIL wait_state got %b want %b", st, S_BUSY); end
        step();
        nvec++; if (st !== S_BUSY) begin nerr++; $display("FAIL wait_hold got %b want %b", st, S_BUSY); end
        fifo_empty = 3'b111; fifo_full = 3'b000;
        step();
        nvec++; if (st !== S_LFD) begin nerr++; $display("FAIL wait_to_lfd got %b want %b", st, S_LFD); end
        step();
        pkt_valid = 1'b0;
        step(); step(); step();
        nvec++; if (st !== S_DEC) begin nerr++; $display("FAIL wait_end got %b want %b", st, S_DEC); end
        nvec++; if (wcnt[2] != 2) begin nerr++; $display("FAIL wait_wen2_count got %0d want 2", wcnt[2]); end
    endtask

    task automatic test_fifo_full();
        pkt_valid = 1'b1; data_in = 2'b00;
        step(); step(); step();
        nvec++; if (st !== S_LD) begin nerr++; $display("FAIL full_pre got %b want %b", st, S_LD); end
        fifo_full = 3'b001;
        step();
        nvec++; if (st !== S_FFS || write_enb !== 3'b000) begin
            nerr++; $display("FAIL full_enter got %b/%b want %b/000", st, write_enb, S_FFS); end
        step();
        nvec++; if (st !== S_FFS || write_enb !== 3'b000) begin
            nerr++; $display("FAIL full_hold got %b/%b want %b/000", st, write_enb, S_FFS); end
        fifo_full = 3'b000;
        step();
        nvec++; if (st !== S_LAF || write_enb !== 3'b000) begin
            nerr++; $display("FAIL full_laf got %b/%b want %b/000", st, write_enb, S_LAF); end
        step();
        nvec++; if (st !== S_LD || write_enb !== 3'b001) begin
            nerr++; $display("FAIL full_back_ld got %b/%b want %b/001", st, write_enb, S_LD); end
        pkt_valid = 1'b0;
        step(); step(); step();
        nvec++; if (st !== S_DEC) begin nerr++; $display("FAIL full_end got %b want %b", st, S_DEC); end
    endtask

    task automatic test_drop();
        pkt_valid = 1'b1; data_in = 2'b11;
        for (int i = 0; i < 5; i++) begin
            step();
            nvec++;
            if (st !== S_DROP || write_enb !== 3'b000) begin
                nerr++; $display("FAIL drop[%0d] got %b/%b want %b/000", i, st, write_enb, S_DROP); end
        end
        pkt_valid = 1'b0;
        step();
        nvec++; if (st !== S_DEC) begin nerr++; $display("FAIL drop_exit got %b want %b", st, S_DEC); end
    endtask

    task automatic test_soft_reset();
        logic [2:0] exp_sr;
        pkt_valid = 1'b1; data_in = 2'b10;
        step(); step();
        fifo_full = 3'b100; fifo_empty = 3'b011;
        for (int i = 1; i <= 31; i++) begin
            if (i == 31) pkt_valid = 1'b0;
            step();
            exp_sr = (i == 30) ? 3'b100 : 3'b000;
            nvec++;
            if (soft_reset !== exp_sr) begin nerr++; $display("FAIL srst_fsm[%0d] got %b want %b", i, soft_reset, exp_sr); end
            nvec++;
            if (st !== ((i == 31) ? S_DEC : S_FFS)) begin nerr++; $display("FAIL srst_state[%0d] got %b", i, st); end
        end
        fifo_full = 3'b000; fifo_empty = 3'b111;
        step();
        fifo_empty = 3'b011;
        for (int i = 1; i <= 85; i++) begin
            read_enb = (i == 20 || i == 81) ? 3'b100 : 3'b000;
            step();
            exp_sr = (i == 50) ? 3'b100 : 3'b000;
            nvec++;
            if (soft_reset !== exp_sr) begin nerr++; $display("FAIL srst_read[%0d] got %b want %b", i, soft_reset, exp_sr); end
        end
        read_enb = 3'b000; fifo_empty = 3'b111;
        step();
    endtask

    task automatic test_mid_reset();
        pkt_valid = 1'b1; data_in = 2'b01;
        step(); step(); step();
        nvec++; if (st !== S_LD || write_enb !== 3'b010) begin
            nerr++; $display("FAIL mrst_pre got %b/%b want %b/010", st, write_enb, S_LD); end
        resetn = 1'b0; pkt_valid = 1'b0;
        step();
        nvec++; if (st !== S_DEC || write_enb !== 3'b000) begin
            nerr++; $display("FAIL mrst_state got %b/%b want %b/000", st, write_enb, S_DEC); end
        nvec++; if (dut.addr_q !== 2'b00) begin nerr++; $display("FAIL mrst_addr got %b want 00", dut.addr_q); end
        resetn = 1'b1;
        step();
        nvec++; if (st !== S_DEC || write_enb !== 3'b000) begin
            nerr++; $display("FAIL mrst_after got %b/%b want %b/000", st, write_enb, S_DEC); end
    endtask

    initial begin
        test_reset();
        test_packet();
        test_wait_empty();
        test_fifo_full();
        test_drop();
        test_soft_reset();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
